arm_alu_seq: RTL and testbench
==============================

Name: arm_alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU in the ARM-subset datapath.
- Adds EOR, RSB, MUL and MLA to ADD/SUB/AND/ORR, over a configurable data width.
- Single-cycle ops finish in one cycle; MUL/MLA use an iterative shift-add engine with optional early termination.
- Sits between register-file read and the result mux of the multicycle core. Uses a valid/ready handshake on input and output.

Parameters:
- WIDTH, 32: operand/result width in bits (>=8).
- EARLY_TERM, 1: 1 = MUL/MLA stops once the remaining multiplier bits are zero; 0 = always WIDTH steps.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 RSB (b-a), 110 MUL, 111 MLA.
- a  input  WIDTH  operand A (MUL multiplicand).
- b  input  WIDTH  operand B (MUL multiplier).
- c  input  WIDTH  MLA accumulate operand; ignored otherwise.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result, low WIDTH bits.
- flags  output  4  registered {N,Z,C,V}.
- busy  output  1  multiply iteration in progress.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state <= IDLE; result, flags, accumulator and shift registers <= 0; step counter <= 0.
  - Reset aborts any operation in progress, including mid-multiply and in DONE.
  - While reset is low, in_valid is ignored.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==MUL).
  - out_valid = (state==DONE).
- Accept occurs on an edge where state==IDLE and in_valid==1.
- IDLE, op 000-101 accepted:
  - result/flags computed combinationally and registered at the accept edge; state <= DONE.
  - Latency 1 edge.
- IDLE, op 110/111 accepted:
  - acc <= (MLA ? c : 0); ma <= a; mb <= b; cnt <= 0.
  - If EARLY_TERM and b==0: result <= acc init value, state <= DONE (latency 1).
  - Otherwise state <= MUL.
- MUL, each edge:
  - if mb[0], acc <= acc + ma (mod 2^WIDTH); ma <= ma<<1; mb <= mb>>1; cnt++.
  - Go to DONE and register result/flags when cnt+1==WIDTH, or when EARLY_TERM and (mb>>1)==0.
  - Latency 1+k, where k = position of the highest set bit of b, plus 1 (EARLY_TERM=1), or k = WIDTH (EARLY_TERM=0).
- DONE:
  - result and flags are held stable.
  - On out_ready==1, state <= IDLE.
  - No accept while in DONE. Throughput for single-cycle ops is one result per 2 cycles.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB/RSB: C = NOT borrow (minuend + ~subtrahend + 1); V = signed overflow.
  - AND/ORR/EOR/MUL/MLA: C = 0, V = 0.
- Inputs a, b, c, op are sampled only at the accept edge; later changes have no effect.
- Handshake with in_valid held while in_ready=0: no effect; the requester must hold the request.

Decomposition:
- Package arm_alu_pkg:
  - alu_op_t enum (3-bit encodings above).
  - alu_state_t enum {IDLE, MUL, DONE}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, arm_addsub (parameter WIDTH): inputs x, y, sub; outputs sum and {C,V}. It is reused for ADD/SUB/RSB.
- The multiply datapath stays in arm_alu_seq.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, flags 1001; out_valid on the first edge after accept.
- SUB a=5, b=5 -> 0, flags 0110. RSB a=1, b=0 -> 0xFFFFFFFF, flags 1000.
- MUL a=6, b=7:
  - EARLY_TERM=1 -> 42; busy high 3 cycles; out_valid after 4 edges.
  - EARLY_TERM=0 -> 42 after 33 edges.
- MLA a=0xFFFFFFFF, b=2, c=3 -> result 1, flags 0000, latency 3. MUL with b=0, EARLY_TERM=1 -> 0, flags 0100, latency 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> result/flags unchanged, in_ready=0, a concurrent in_valid is not accepted.
  - Then out_ready=1 -> IDLE next edge, and the pending request is accepted on the following edge.
- Reset low at multiply step 10 (b=0xFFFFFFFF) -> next edge: busy=0, out_valid=0, result=0, flags=0. After release, in_ready=1 and a new ADD 2+3=5 completes normally.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared types and constants for the sequential ARM-subset ALU.
package arm_alu_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOrr = 3'b011,
        OpEor = 3'b100,
        OpRsb = 3'b101,
        OpMul = 3'b110,
        OpMla = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } alu_state_t;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FlagN] = n;
        f[FlagZ] = z;
        f[FlagC] = c;
        f[FlagV] = v;
        return f;
    endfunction

endpackage

// File: rtl/arm_addsub.sv
// Shared adder/subtractor for ADD, SUB and RSB; cv = {carry/not-borrow, signed overflow}.
module arm_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic [1:0]       cv
);

    logic [WIDTH-1:0] y_eff;
    logic             carry;

    always_comb begin
        y_eff        = sub ? ~y : y;
        {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
        // Overflow: operands agree in sign but the sum does not.
        cv = {carry, (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1])};
    end

endmodule

// File: rtl/arm_alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative shift-add MUL/MLA,
// with valid/ready handshakes on both sides.
module arm_alu_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    import arm_alu_pkg::*;

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, ma_q, mb_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    alu_op_t          op_e;
    logic [WIDTH-1:0] as_x, as_y, as_sum;
    logic             as_sub;
    logic [1:0]       as_cv;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;
    logic             is_mul, mul_skip, mul_last;
    logic [WIDTH-1:0] acc_init, acc_step;

    arm_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .x  (as_x),
        .y  (as_y),
        .sub(as_sub),
        .sum(as_sum),
        .cv (as_cv)
    );

    always_comb begin
        op_e   = alu_op_t'(op);
        as_x   = a;
        as_y   = b;
        as_sub = 1'b0;
        unique case (op_e)
            OpSub: as_sub = 1'b1;
            OpRsb: begin
                as_x   = b;
                as_y   = a;
                as_sub = 1'b1;
            end
            default: ;
        endcase

        alu_res = as_sum;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_e)
            OpAdd, OpSub, OpRsb: begin
                alu_c = as_cv[1];
                alu_v = as_cv[0];
            end
            OpAnd:   alu_res = a & b;
            OpOrr:   alu_res = a | b;
            OpEor:   alu_res = a ^ b;
            default: ;
        endcase
        alu_flags = pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);

        is_mul   = (op_e == OpMul) || (op_e == OpMla);
        acc_init = (op_e == OpMla) ? c : '0;
        mul_skip = EARLY_TERM && (b == '0);
        acc_step = mb_q[0] ? acc_q + ma_q : acc_q;
        mul_last = (cnt_q == CntLast) || (EARLY_TERM && (mb_q[WIDTH-1:1] == '0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (is_mul && !mul_skip) ? StMul : StDone;
                end
            end
            StMul:   if (mul_last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StMul);
        out_valid = (state_q == StDone);
        result    = result_q;
        flags     = flags_q;
    end

    // Operands are captured only at the accept edge; result/flags hold until consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            acc_q <= acc_init;
                            ma_q  <= a;
                            mb_q  <= b;
                            cnt_q <= '0;
                            if (mul_skip) begin
                                result_q <= acc_init;
                                flags_q  <= pack_flags(acc_init[WIDTH-1], acc_init == '0,
                                                       1'b0, 1'b0);
                            end
                        end else begin
                            result_q <= alu_res;
                            flags_q  <= alu_flags;
                        end
                    end
                end
                StMul: begin
                    acc_q <= acc_step;
                    ma_q  <= ma_q << 1;
                    mb_q  <= mb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_last) begin
                        result_q <= acc_step;
                        flags_q  <= pack_flags(acc_step[WIDTH-1], acc_step == '0, 1'b0, 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Self-checking bench for arm_alu_seq: vector table, backpressure, reset-abort and
// a non-early-terminating instance for full-length multiply latency.
module tb_arm_alu_seq;

    import arm_alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    typedef struct {
        alu_op_t      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           lat;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]   op;
    logic [W-1:0] a, b, c, result;
    logic [3:0]   flags;

    logic         nt_in_valid, nt_in_ready, nt_out_valid, nt_out_ready, nt_busy;
    logic [2:0]   nt_op;
    logic [W-1:0] nt_a, nt_b, nt_c, nt_result;
    logic [3:0]   nt_flags;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    arm_alu_seq #(
        .WIDTH(W),
        .EARLY_TERM(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .c        (c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .busy     (busy)
    );

    arm_alu_seq #(
        .WIDTH(W),
        .EARLY_TERM(1'b0)
    ) dut_nt (
        .clk      (clk),
        .reset    (reset),
        .in_valid (nt_in_valid),
        .in_ready (nt_in_ready),
        .op       (nt_op),
        .a        (nt_a),
        .b        (nt_b),
        .c        (nt_c),
        .out_valid(nt_out_valid),
        .out_ready(nt_out_ready),
        .result   (nt_result),
        .flags    (nt_flags),
        .busy     (nt_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " result"}, result, e.res);
            chk({nm, " flags"}, 32'(flags), 32'(e.flg));
        end
    endtask

    task automatic run_op(input alu_op_t o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] vc, input logic [W-1:0] er, input logic [3:0] ef,
                          input int el, input string nm);
        int lat;
        int bcnt;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        op       = o;
        a        = va;
        b        = vb;
        c        = vc;
        in_valid = 1'b1;
        sb.push_back('{res: er, flg: ef});
        tick();
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
        c        = $urandom;
        lat      = 1;
        bcnt     = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(el));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(el - 1));
        pop_chk(nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{OpAdd, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 4'b1001, 1, "add_ovf"};
        vecs[1]  = '{OpAdd, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h00000000, 4'b0110, 1, "add_carry"};
        vecs[2]  = '{OpSub, 32'h5, 32'h5, 32'h0, 32'h0, 4'b0110, 1, "sub_eq"};
        vecs[3]  = '{OpSub, 32'h80000000, 32'h1, 32'h0, 32'h7FFFFFFF, 4'b0011, 1, "sub_ovf"};
        vecs[4]  = '{OpRsb, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b1000, 1, "rsb_neg"};
        vecs[5]  = '{OpAnd, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 4'b1000, 1, "and"};
        vecs[6]  = '{OpOrr, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100, 1, "orr_zero"};
        vecs[7]  = '{OpEor, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'hAAAAAAAA, 4'b1000, 1, "eor"};
        vecs[8]  = '{OpMul, 32'h6, 32'h7, 32'h0, 32'd42, 4'b0000, 4, "mul_6x7"};
        vecs[9]  = '{OpMla, 32'hFFFFFFFF, 32'h2, 32'h3, 32'h1, 4'b0000, 3, "mla_wrap"};
        vecs[10] = '{OpMul, 32'h5, 32'h0, 32'h9, 32'h0, 4'b0100, 1, "mul_b0"};
        vecs[11] = '{OpMul, 32'h10000, 32'h10000, 32'h0, 32'h0, 4'b0100, 18, "mul_ovfl"};
        vecs[12] = '{OpMla, 32'h7, 32'h0, 32'h80000000, 32'h80000000, 4'b1000, 1, "mla_b0"};

        reset        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        op           = '0;
        a            = '0;
        b            = '0;
        c            = '0;
        nt_in_valid  = 1'b0;
        nt_out_ready = 1'b0;
        nt_op        = '0;
        nt_a         = '0;
        nt_b         = '0;
        nt_c         = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst flags", 32'(flags), 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].flg,
                   vecs[i].lat, vecs[i].name);
        end

        // Backpressure: result held, pending request refused until consumer drains.
        op       = OpAdd;
        a        = 32'd2;
        b        = 32'd3;
        in_valid = 1'b1;
        sb.push_back('{res: 32'd5, flg: 4'b0000});
        tick();
        op = OpOrr;
        a  = 32'd1;
        b  = 32'd2;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        pop_chk("bp first");
        sb.push_back('{res: 32'd3, flg: 4'b0000});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold result", result, 32'd5);
            chk("bp hold flags", 32'(flags), 32'd0);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp idle out_valid", 32'(out_valid), 32'd0);
        chk("bp idle in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp pending out_valid", 32'(out_valid), 32'd1);
        pop_chk("bp pending");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-multiply aborts; requests during reset are ignored.
        op       = OpMul;
        a        = 32'd3;
        b        = 32'hFFFFFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("rstmul busy_before", 32'(busy), 32'd1);
        reset    = 1'b0;
        op       = OpAdd;
        a        = 32'd7;
        b        = 32'd7;
        in_valid = 1'b1;
        tick();
        chk("rstmul busy", 32'(busy), 32'd0);
        chk("rstmul out_valid", 32'(out_valid), 32'd0);
        chk("rstmul result", result, 32'd0);
        chk("rstmul flags", 32'(flags), 32'd0);
        tick();
        chk("rstmul ignore_req", 32'(out_valid), 32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("rstmul in_ready", 32'(in_ready), 32'd1);
        run_op(OpAdd, 32'd2, 32'd3, 32'd0, 32'd5, 4'b0000, 1, "post_rst_add");

        // Full-length multiply without early termination.
        nt_op       = OpMul;
        nt_a        = 32'd6;
        nt_b        = 32'd7;
        nt_in_valid = 1'b1;
        tick();
        nt_in_valid = 1'b0;
        lat = 1;
        while (!nt_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("nt out_valid", 32'(nt_out_valid), 32'd1);
        chk("nt latency", 32'(lat), 32'd33);
        chk("nt result", nt_result, 32'd42);
        chk("nt flags", 32'(nt_flags), 32'd0);
        nt_out_ready = 1'b1;
        tick();
        nt_out_ready = 1'b0;
        chk("nt drained", 32'(nt_in_ready), 32'd1);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
